// File: rtl/seq_div_16x8_if.sv
// Handshake bundle for the seq_div_16x8 restoring divider: operand request and
// result response, each with its own valid/ready pair.
interface seq_div_16x8_if #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_N-1:0] A;
    logic [WIDTH_D-1:0] B;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_N-1:0] Q;
    logic [WIDTH_D-1:0] REM;
    logic               div0;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Q, REM, div0
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Q, REM, div0
    );
endinterface

// File: rtl/seq_div_16x8.sv
// Sequential restoring divider, WIDTH_N / WIDTH_D, one quotient bit per clock.
// Define APPROX_DIV_EN to skip the low TRUNC quotient bits for shorter latency.
module seq_div_16x8 #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8,
    parameter int TRUNC   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_div_16x8_if.slave  bus
);

`ifdef APPROX_DIV_EN
    localparam int ITER = WIDTH_N - TRUNC;
`else
    localparam int ITER = WIDTH_N;
`endif
    localparam int CW = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH_N-1:0] r_dvd;
    logic [WIDTH_N-1:0] r_q;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_D-1:0] r_b;
    logic               r_div0;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH_D:0]   w_shift;
    logic               w_ge;
    logic [WIDTH_D-1:0] w_diff;
    logic [WIDTH_N-1:0] w_qnext;

    assign w_accept = (r_state == IDLE) && r_in_ready && bus.in_valid;
    assign w_last   = (r_cnt == CW'(1));

    // Partial remainder is WIDTH_D+1 bits only for the duration of the shift.
    // When the trial succeeds the true difference is below B, so its low
    // WIDTH_D bits are exact.
    assign w_shift = {r_rem, r_dvd[WIDTH_N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[WIDTH_D-1:0] - r_b;
    assign w_qnext = {r_q[WIDTH_N-2:0], w_ge};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)      w_next = BUSY;
            BUSY:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and comes up on
    // the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == IDLE);
        end
    end

    // A zero divisor spends its single BUSY cycle idling so the flagged result
    // appears one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_div0 <= 1'b0;
        end else if (w_accept) begin
            r_b    <= bus.B;
            r_dvd  <= bus.A;
            if (bus.B == '0) begin
                r_cnt  <= CW'(1);
                r_q    <= '1;
                r_rem  <= bus.A[WIDTH_D-1:0];
                r_div0 <= 1'b1;
            end else begin
                r_cnt  <= CW'(ITER);
                r_q    <= '0;
                r_rem  <= '0;
                r_div0 <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            if (!r_div0) begin
                r_dvd <= r_dvd << 1;
                r_rem <= w_ge ? w_diff : w_shift[WIDTH_D-1:0];
`ifdef APPROX_DIV_EN
                r_q   <= w_last ? (w_qnext << TRUNC) : w_qnext;
`else
                r_q   <= w_qnext;
`endif
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.Q         = r_q;
    assign bus.REM       = r_rem;
    assign bus.div0      = r_div0;

endmodule
